// File: rtl/gerador_cruzamento_pkg.sv
// gerador_cruzamento_pkg
// Shared definitions for the zero-crossing test-signal generator: state
// encoding, sample width, default counter width and default amplitude, plus
// a small helper that picks the positive or negative output level.
package gerador_cruzamento_pkg;

    localparam int SAMPLE_W  = 32;
    localparam int CNT_W_DEF = 9;

    localparam logic signed [SAMPLE_W-1:0] AMP_DEF = 32'sd1073741824;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POS  = 2'd1;
    localparam logic [1:0] ST_NEG  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        POS  = ST_POS,
        NEG  = ST_NEG
    } estado_t;

    // Returns +amp when positivo is set, -amp otherwise.
    function automatic logic [SAMPLE_W-1:0] nivel(
        input logic                         positivo,
        input logic signed [SAMPLE_W-1:0]   amp
    );
        return positivo ? amp : -amp;
    endfunction

endpackage

// File: rtl/gerador_cruzamento_divisor_amostra.sv
// divisor_amostra
// Sample-rate tick generator: counts 0..DIV-1 while enabled and not cleared,
// and raises tick for one clock when the count sits at DIV-1.
//
// Ports:
//   clk     system clock
//   reset   asynchronous reset, active-high
//   enable  count request; 0 forces the count back to 0
//   clear   synchronous clear (generator idle); has priority over counting
//   tick    one-clock pulse, once every DIV clocks while running
module divisor_amostra
    import gerador_cruzamento_pkg::*;
#(
    parameter int DIV = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int                DIV_W  = $clog2(DIV);
    localparam logic [DIV_W-1:0]  ULTIMO = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] contador;

    // Gated so a stale count can never produce a tick while stopped.
    assign tick = enable && !clear && (contador == ULTIMO);

    // Free-running modulo-DIV counter, held at 0 whenever the generator
    // is stopped so the first tick after a start lands exactly DIV clocks
    // later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contador <= '0;
        end else if (!enable || clear) begin
            contador <= '0;
        end else if (contador == ULTIMO) begin
            contador <= '0;
        end else begin
            contador <= contador + DIV_W'(1);
        end
    end

endmodule

// File: rtl/gerador_cruzamento.sv
// gerador_cruzamento
// Square-wave test-signal transmitter for the zero-crossing frequency chain.
// Emits +AMP for N samples, then -AMP for N samples, and so on, one sample
// every DIV clocks, so consecutive sign changes are exactly N samples apart.
//
// Ports:
//   clk             system clock
//   reset           asynchronous reset, active-high
//   enable          run request; 0 stops the generator and returns to idle
//   periodo_in      requested half-period N in samples
//   periodo_valid   one-cycle load strobe for periodo_in (0 is ignored)
//   saida           signed sample, valid on amostra_pronta, held otherwise
//   amostra_pronta  one-clock sample strobe
//   cruzou          one-clock pulse on the first sample after a sign change
//   periodo_ativo   half-period currently being generated
module gerador_cruzamento
    import gerador_cruzamento_pkg::*;
#(
    parameter int                          DIV   = 1024,
    parameter logic signed [SAMPLE_W-1:0]  AMP   = AMP_DEF,
    parameter int                          CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_W-1:0]     periodo_in,
    input  logic                 periodo_valid,
    output logic [SAMPLE_W-1:0]  saida,
    output logic                 amostra_pronta,
    output logic                 cruzou,
    output logic [CNT_W-1:0]     periodo_ativo
);

    estado_t              estado, estado_nxt;
    logic [SAMPLE_W-1:0]  saida_nxt;
    logic                 amostra_nxt;
    logic                 cruzou_nxt;
    logic [CNT_W-1:0]     periodo_nxt;
    logic [CNT_W-1:0]     contagem, contagem_nxt;
    logic [CNT_W-1:0]     pendente, pendente_nxt;
    logic                 pendente_valido, pendente_valido_nxt;
    logic                 consome;
    logic                 tick;
    logic                 parado;

    assign parado = (estado == IDLE);

    divisor_amostra #(
        .DIV (DIV)
    ) u_divisor (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (parado),
        .tick   (tick)
    );

    // Next-state and next-output logic. A half-period ends when the sample
    // count reaches periodo_ativo; the count restarts at 1 because the
    // boundary sample itself is the first sample of the new half. The count
    // starts at 0 only when leaving IDLE, so the first half is also N long.
    // cruzou is derived from the level actually changing, which covers both
    // the ordinary boundary and the 0 -> +AMP step out of IDLE.
    always_comb begin
        estado_nxt   = estado;
        saida_nxt    = saida;
        amostra_nxt  = 1'b0;
        periodo_nxt  = periodo_ativo;
        contagem_nxt = contagem;
        consome      = 1'b0;

        if (!enable) begin
            estado_nxt = IDLE;
            saida_nxt  = '0;
        end else begin
            case (estado)
                IDLE: begin
                    saida_nxt = '0;
                    if (pendente_valido) begin
                        periodo_nxt  = pendente;
                        consome      = 1'b1;
                        contagem_nxt = '0;
                        estado_nxt   = POS;
                    end else if (periodo_ativo != '0) begin
                        contagem_nxt = '0;
                        estado_nxt   = POS;
                    end
                end
                POS, NEG: begin
                    if (tick) begin
                        amostra_nxt = 1'b1;
                        if (contagem < periodo_ativo) begin
                            saida_nxt    = nivel(estado == POS, AMP);
                            contagem_nxt = contagem + CNT_W'(1);
                        end else begin
                            if (pendente_valido) begin
                                periodo_nxt = pendente;
                                consome     = 1'b1;
                            end
                            saida_nxt    = nivel(estado == NEG, AMP);
                            contagem_nxt = CNT_W'(1);
                            estado_nxt   = (estado == POS) ? NEG : POS;
                        end
                    end
                end
                default: begin
                    estado_nxt = IDLE;
                    saida_nxt  = '0;
                end
            endcase
        end

        cruzou_nxt = amostra_nxt && (saida_nxt != saida);

        // A fresh load wins over consumption in the same cycle, so a value
        // written on a boundary edge waits for the following boundary.
        pendente_nxt        = pendente;
        pendente_valido_nxt = pendente_valido;
        if (periodo_valid && (periodo_in != '0)) begin
            pendente_nxt        = periodo_in;
            pendente_valido_nxt = 1'b1;
        end else if (consome) begin
            pendente_valido_nxt = 1'b0;
        end
    end

    // State, counters, pending register and all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado          <= IDLE;
            saida           <= '0;
            amostra_pronta  <= 1'b0;
            cruzou          <= 1'b0;
            periodo_ativo   <= '0;
            contagem        <= '0;
            pendente        <= '0;
            pendente_valido <= 1'b0;
        end else begin
            estado          <= estado_nxt;
            saida           <= saida_nxt;
            amostra_pronta  <= amostra_nxt;
            cruzou          <= cruzou_nxt;
            periodo_ativo   <= periodo_nxt;
            contagem        <= contagem_nxt;
            pendente        <= pendente_nxt;
            pendente_valido <= pendente_valido_nxt;
        end
    end

endmodule

// File: tb/tb_gerador_cruzamento.sv
// tb_gerador_cruzamento
// Self-checking bench for gerador_cruzamento. A sample-level reference model
// (sign, samples left in the current half, pending half-period) predicts
// each strobe; a monitor compares the DUT against those predictions.
module tb_gerador_cruzamento;

    localparam int                 DIV   = 4;
    localparam int                 CNT_W = 9;
    localparam logic signed [31:0] AMP   = 32'sd1000;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [CNT_W-1:0]  periodo_in;
    logic              periodo_valid;
    logic [31:0]       saida;
    logic              amostra_pronta;
    logic              cruzou;
    logic [CNT_W-1:0]  periodo_ativo;

    gerador_cruzamento #(
        .DIV   (DIV),
        .AMP   (AMP),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .periodo_in     (periodo_in),
        .periodo_valid  (periodo_valid),
        .saida          (saida),
        .amostra_pronta (amostra_pronta),
        .cruzou         (cruzou),
        .periodo_ativo  (periodo_ativo)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int               cyc;
        logic [31:0]      valor;
        logic             cruz;
        logic [CNT_W-1:0] per;
    } amostra_t;

    amostra_t fila[$];
    amostra_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, at the level of "what the waveform looks like".
    int               m_cyc       = 0;
    int               m_next      = 0;
    int               m_sign      = 0;
    int               m_last      = 0;
    int               m_remaining = 0;
    bit               m_running   = 1'b0;
    logic [CNT_W-1:0] m_half      = '0;
    logic [CNT_W-1:0] m_pending   = '0;
    bit               m_pvalid    = 1'b0;

    task automatic checkOutput(input string nome, input logic [31:0] atual,
                               input logic [31:0] esperado);
        n_checks++;
        if (atual === esperado) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at cycle %0d",
                     nome, $signed(atual), atual, $signed(esperado), esperado, m_cyc);
        end
    endtask

    task automatic modelReset();
        m_running   = 1'b0;
        m_sign      = 0;
        m_last      = 0;
        m_remaining = 0;
        m_half      = '0;
        m_pending   = '0;
        m_pvalid    = 1'b0;
        fila.delete();
    endtask

    // One clock edge of the reference model: stopping, starting, emitting a
    // sample when one is due, then latching any new load.
    task automatic modelEdge(input logic en, input logic pv, input logic [CNT_W-1:0] pin);
        amostra_t e;
        m_cyc++;
        if (!en) begin
            m_running = 1'b0;
            m_last    = 0;
        end else if (!m_running) begin
            bit start;
            start = 1'b0;
            if (m_pvalid) begin
                m_half   = m_pending;
                m_pvalid = 1'b0;
                start    = 1'b1;
            end else if (m_half != 0) begin
                start = 1'b1;
            end
            if (start) begin
                m_running   = 1'b1;
                m_sign      = 1;
                m_last      = 0;
                m_remaining = int'(m_half);
                m_next      = m_cyc + DIV;
            end
        end else if (m_cyc == m_next) begin
            if (m_remaining == 0) begin
                if (m_pvalid) begin
                    m_half   = m_pending;
                    m_pvalid = 1'b0;
                end
                m_sign      = -m_sign;
                m_remaining = int'(m_half);
            end
            m_remaining--;
            e.cyc   = m_cyc;
            e.valor = (m_sign > 0) ? AMP : -AMP;
            e.cruz  = (m_sign != m_last);
            e.per   = m_half;
            m_last  = m_sign;
            fila.push_back(e);
            m_next  = m_next + DIV;
        end
        if (pv && (pin != 0)) begin
            m_pending = pin;
            m_pvalid  = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic applyStimulus(input logic en, input logic pv, input logic [CNT_W-1:0] pin);
        enable        = en;
        periodo_valid = pv;
        periodo_in    = pin;
        @(posedge clk);
        modelEdge(en, pv, pin);
        @(negedge clk);
    endtask

    function automatic bit modelCond(input int kind);
        case (kind)
            1: return m_running && (m_remaining == 0) && (m_next == m_cyc + 1);
            2: return m_running && (m_sign < 0);
            3: return m_running && (m_sign > 0) && (m_remaining == int'(m_half) - 2);
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitFor(input int kind, input int limite, input string nome);
        int n;
        n = 0;
        while (!modelCond(kind) && n < limite) begin
            applyStimulus(1'b1, 1'b0, '0);
            n++;
        end
        n_checks++;
        if (modelCond(kind)) n_pass++;
        else $display("[TB] FAIL %s: condition not reached within %0d cycles", nome, limite);
    endtask

    // Reset asserted in the middle of the low clock phase; outputs must
    // clear without waiting for an edge.
    task automatic applyReset();
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_saida",   saida, 32'd0);
        checkOutput("reset_strobe",  {31'd0, amostra_pronta}, 32'd0);
        checkOutput("reset_cruzou",  {31'd0, cruzou}, 32'd0);
        checkOutput("reset_periodo", {23'd0, periodo_ativo}, 32'd0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: every strobe must match the head of the expected queue,
    // expected strobes must not be skipped, and cruzou never pulses alone.
    always @(negedge clk) begin
        if (!reset) begin
            if (amostra_pronta) begin
                if (fila.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_strobe: got strobe with saida %0d, expected none at cycle %0d",
                             $signed(saida), m_cyc);
                end else begin
                    mon_e = fila.pop_front();
                    checkOutput("strobe_cycle", m_cyc, mon_e.cyc);
                    checkOutput("saida", saida, mon_e.valor);
                    checkOutput("cruzou", {31'd0, cruzou}, {31'd0, mon_e.cruz});
                    checkOutput("periodo_ativo", {23'd0, periodo_ativo}, {23'd0, mon_e.per});
                end
            end else begin
                checkOutput("cruzou_quiet", {31'd0, cruzou}, 32'd0);
                if (fila.size() > 0 && fila[0].cyc <= m_cyc) begin
                    mon_e = fila.pop_front();
                    n_checks++;
                    $display("[TB] FAIL missing_strobe: got none, expected strobe at cycle %0d", mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        periodo_valid = 1'b0;
        periodo_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("por_saida",   saida, 32'd0);
        checkOutput("por_strobe",  {31'd0, amostra_pronta}, 32'd0);
        checkOutput("por_cruzou",  {31'd0, cruzou}, 32'd0);
        checkOutput("por_periodo", {23'd0, periodo_ativo}, 32'd0);
        #1 reset = 1'b0;

        // Stopped after reset: no strobes at all.
        repeat (5000) applyStimulus(1'b0, 1'b0, '0);

        // Basic run, N=4.
        applyStimulus(1'b1, 1'b1, 9'd4);
        repeat (60) applyStimulus(1'b1, 1'b0, '0);

        // Mid-run change to N=2 during the second positive sample.
        waitFor(3, 100, "wait_second_pos");
        applyStimulus(1'b1, 1'b1, 9'd2);
        repeat (60) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("periodo_after_change", {23'd0, periodo_ativo}, 32'd2);

        // Load of zero is ignored.
        applyStimulus(1'b1, 1'b1, 9'd0);
        repeat (40) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("periodo_load0", {23'd0, periodo_ativo}, 32'd2);

        // N=1: alternating signs, crossing on every sample.
        applyStimulus(1'b1, 1'b1, 9'd1);
        repeat (40) applyStimulus(1'b1, 1'b0, '0);

        // N=511: largest half-period, counter must not wrap.
        applyStimulus(1'b1, 1'b1, 9'd511);
        repeat ((3 * 511 + 4) * DIV) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("periodo_511", {23'd0, periodo_ativo}, 32'd511);

        // Same-cycle load on a boundary tick.
        applyStimulus(1'b1, 1'b1, 9'd2);
        waitFor(1, 2 * 511 * DIV + 20, "wait_boundary_a");
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 9'd3);
        waitFor(1, 100, "wait_boundary_b");
        applyStimulus(1'b1, 1'b1, 9'd1);
        checkOutput("periodo_same_cycle", {23'd0, periodo_ativo}, 32'd3);
        waitFor(1, 100, "wait_boundary_c");
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("periodo_next_boundary", {23'd0, periodo_ativo}, 32'd1);

        // Stop during NEG, then restart from the kept half-period.
        applyStimulus(1'b1, 1'b1, 9'd4);
        repeat (20) applyStimulus(1'b1, 1'b0, '0);
        waitFor(2, 100, "wait_neg_stop");
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("stop_saida",   saida, 32'd0);
        checkOutput("stop_strobe",  {31'd0, amostra_pronta}, 32'd0);
        checkOutput("stop_periodo", {23'd0, periodo_ativo}, 32'd4);
        repeat (10) applyStimulus(1'b0, 1'b0, '0);
        repeat (40) applyStimulus(1'b1, 1'b0, '0);

        // Randomized loads and enable drops.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 149) != 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                          9'($urandom_range(0, 6)));
        end

        // Reset during NEG: needs a reload before it runs again.
        applyStimulus(1'b1, 1'b1, 9'd3);
        waitFor(2, 200, "wait_neg_reset");
        applyReset();
        repeat (50) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("reset_keeps_idle", {23'd0, periodo_ativo}, 32'd0);
        applyStimulus(1'b1, 1'b1, 9'd2);
        repeat (40) applyStimulus(1'b1, 1'b0, '0);

        repeat (2) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("queue_drained", fila.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gerador_cruzamento.md
Name: gerador_cruzamento

Overview:
- Test-signal transmitter for the zero-crossing frequency measurement chain. It is the other end of the zero_cross interface.
- Takes a requested half-period N, in samples, and emits a signed 32-bit square-wave sample stream with a one-clock sample strobe.
- Zero crossings in the stream are exactly N samples apart, so zero_cross, fed directly, reports cnt = N.
- Used for closed-loop bring-up and self-test of the interpolator/zero_cross path.

Parameters:
- DIV, 1024: clk cycles per output sample; legal range is 2 or more.
- AMP, 32'sd1073741824: positive peak value. The negative level is -AMP.
- CNT_W, 9: width of the period and sample counters. Matches zero_cross cnt.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- enable  input  1  run request; 0 stops the generator and returns it to idle
- periodo_in  input  CNT_W  requested half-period N in samples
- periodo_valid  input  1  one-cycle load strobe for periodo_in
- saida  output  32  signed sample; valid when amostra_pronta=1, held otherwise
- amostra_pronta  output  1  one-clock sample strobe
- cruzou  output  1  one-clock pulse, coincident with amostra_pronta, on the first sample after a sign change
- periodo_ativo  output  CNT_W  half-period currently being generated

Behaviour:
- Reset (async, any time, including mid-operation):
  - saida=0, amostra_pronta=0, cruzou=0, periodo_ativo=0.
  - Pending register = 0 with its valid flag cleared; divider=0; sample count=0; state=IDLE.
- Load path:
  - periodo_valid=1 with periodo_in≠0 writes the pending register and sets its valid flag.
  - periodo_in=0 is ignored.
  - A later load overwrites an unapplied pending value.
- Divider:
  - Counts 0..DIV-1 only while enable=1 and state≠IDLE.
  - tick = (divider==DIV-1).
  - The divider is forced to 0 whenever enable=0.
- All outputs are registered. On tick, saida, amostra_pronta and cruzou update in the same clock edge.
- State IDLE:
  - saida=0, no strobes.
  - When enable=1 and the pending flag is set: periodo_ativo←pending, clear the flag, sample count←0, go to POS.
  - The first strobe occurs DIV cycles after entering POS.
- State POS, on tick:
  - If sample count < periodo_ativo: emit +AMP, count+1, cruzou=0.
  - Else (boundary): if pending is valid, periodo_ativo←pending and clear the flag. Then emit -AMP, count←1, cruzou=1, go to NEG.
- State NEG: mirror of POS, emitting -AMP and switching to POS with +AMP at the boundary.
- Boundary decision uses values registered before the edge. A load in the same cycle as a boundary tick takes effect at the following boundary.
- First sample after entering POS from IDLE: cruzou=1, because the sign changes from 0 to +.
- N=1: output alternates sign every sample and cruzou=1 on every strobe.
- N=2^CNT_W-1 (511): the counter must not overflow; the boundary is reached at count==511.
- enable drops mid-run:
  - Next edge: state→IDLE, saida←0, strobes 0.
  - periodo_ativo is kept; a pending value is kept.
  - Re-enable restarts in POS using the pending value if valid, else periodo_ativo if nonzero. Otherwise it stays in IDLE.
- Latency: load to first strobe, from IDLE = 1 + DIV cycles.
- Throughput: exactly one strobe per DIV clocks while running.

Decomposition:
- Shared package: state encoding (IDLE, POS, NEG as 2-bit localparams), sample width 32, CNT_W default, and the AMP default.
- One natural sub-module: divisor_amostra, the DIV-cycle tick generator with enable/clear. The FSM, pending register and output registers stay in gerador_cruzamento.

Test Plan:
- Reset check: assert reset asynchronously mid-clock → all outputs 0 immediately; after release with enable=0, no strobes for 5000 cycles.
- Basic run (DIV=4, AMP=1000):
  - Stimulus: load N=4, enable=1.
  - Strobes every 4 clocks, the first 5 cycles after the load.
  - saida sequence +1000×4, -1000×4, repeating.
  - cruzou on samples 1, 5, 9.
  - Loopback into zero_cross gives cnt=4.
- Mid-run change (N=4):
  - Stimulus: load N=2 during the 2nd +1000 sample.
  - Rest of the current half-period is still 4 samples (+1000×4).
  - Then -1000×2, +1000×2; periodo_ativo changes to 2 at that boundary.
- Edge values:
  - Load 0 → ignored, periodo_ativo unchanged.
  - N=1 → alternating ±1000 with cruzou on every strobe.
  - N=511 → exactly 511 samples per half-period; check no wrap.
- Same-cycle load at a boundary tick: the old pending value is applied, and the new value appears at the next boundary.
- Stop and restart:
  - Stimulus: enable=0 during NEG.
  - Next edge: saida=0, no strobes.
  - Re-enable → restarts with +1000 and cruzou=1, DIV cycles later.
  - Reset during NEG → immediate zeros and IDLE; requires a reload to restart.
